multicycle_ctrl: RTL and testbench

- Multi-cycle control unit for the MIPS core; parametrised successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and stalls on a memory request/acknowledge handshake.
- Adds load/store, beq and j on top of the existing R-type and immediate-ALU set, plus an illegal-opcode trap and a retired-instruction counter.
- Drives the datapath muxes, enables and the ALU opcode.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/multicycle_ctrl_instr_decode.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcode/funct constants, ALU encodings,
// instruction classes and controller state codes.
package mips_pkg;

   // opcode field values
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct field values
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // ALU operation encodings (cast to ALUOP_W at the point of use)
   localparam int ALU_ADD  = 0;
   localparam int ALU_ADDU = 1;
   localparam int ALU_SUBU = 2;
   localparam int ALU_AND  = 3;
   localparam int ALU_OR   = 4;
   localparam int ALU_SLT  = 5;
   localparam int ALU_LUI  = 6;

   // instruction classes produced by the decoder
   typedef enum logic [2:0] {
      CL_R   = 3'd0,
      CL_IMM = 3'd1,
      CL_LW  = 3'd2,
      CL_SW  = 3'd3,
      CL_BEQ = 3'd4,
      CL_J   = 3'd5
   } instr_class_t;

   // controller states
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational opcode/funct decoder: instruction class, ALU operation and
// a legality flag. Unknown opcodes and unknown R-type functs are illegal.
module instr_decode
   import mips_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 6,
   parameter int ALUOP_W = 5
) (
   input  logic [OP_W-1:0]    op,
   input  logic [FUNCT_W-1:0] funct,
   output instr_class_t       cls,
   output logic [ALUOP_W-1:0] aluop,
   output logic               legal
);

   // classify the instruction; every output defaulted first
   always_comb begin
      cls   = CL_R;
      aluop = '0;
      legal = 1'b1;
      case (op)
         OP_W'(OP_RTYPE): begin
            cls = CL_R;
            case (funct)
               FUNCT_W'(FN_ADD):  aluop = ALUOP_W'(ALU_ADD);
               FUNCT_W'(FN_ADDU): aluop = ALUOP_W'(ALU_ADDU);
               FUNCT_W'(FN_SUBU): aluop = ALUOP_W'(ALU_SUBU);
               FUNCT_W'(FN_AND):  aluop = ALUOP_W'(ALU_AND);
               FUNCT_W'(FN_OR):   aluop = ALUOP_W'(ALU_OR);
               FUNCT_W'(FN_SLT):  aluop = ALUOP_W'(ALU_SLT);
               default:           legal = 1'b0;
            endcase
         end
         OP_W'(OP_ADDI):  begin cls = CL_IMM; aluop = ALUOP_W'(ALU_ADD);  end
         OP_W'(OP_ADDIU): begin cls = CL_IMM; aluop = ALUOP_W'(ALU_ADDU); end
         OP_W'(OP_ANDI):  begin cls = CL_IMM; aluop = ALUOP_W'(ALU_AND);  end
         OP_W'(OP_ORI):   begin cls = CL_IMM; aluop = ALUOP_W'(ALU_OR);   end
         OP_W'(OP_LUI):   begin cls = CL_IMM; aluop = ALUOP_W'(ALU_LUI);  end
         OP_W'(OP_LW):    begin cls = CL_LW;  aluop = ALUOP_W'(ALU_ADDU); end
         OP_W'(OP_SW):    begin cls = CL_SW;  aluop = ALUOP_W'(ALU_ADDU); end
         OP_W'(OP_BEQ):   begin cls = CL_BEQ; aluop = ALUOP_W'(ALU_SUBU); end
         OP_W'(OP_J):     cls = CL_J;
         default:         legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit. Sequences FETCH/DECODE/EXEC/MEM/WB with a
// memory req/ack stall, traps on illegal encodings and counts retirements.
// A run flag keeps all strobes low while reset is held and for the cycle in
// which it is released, so the first fetch request appears one cycle later.
// j spends a silent bubble in EXEC after redirecting the PC in DECODE, which
// gives it the same 3-cycle latency as beq.
module multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 6,
   parameter int ALUOP_W = 5,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               alu_zero,
   input  logic               mem_ack,
   output logic               mem_req,
   output logic               mem_we,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               if_extend,
   output logic               alu_src,
   output logic               mem_to_reg,
   output logic [ALUOP_W-1:0] aluop,
   output logic               illegal,
   output logic [CNT_W-1:0]   retired
);

   logic [2:0]         state;
   logic [2:0]         state_nxt;
   logic               run;
   logic               retire;
   logic [OP_W-1:0]    op_q;
   logic [FUNCT_W-1:0] funct_q;
   logic [OP_W-1:0]    dec_op;
   logic [FUNCT_W-1:0] dec_funct;
   instr_class_t       cls;
   logic [ALUOP_W-1:0] dec_aluop;
   logic               legal;

   // DECODE looks at the live IR fields; later states use the latched copy
   assign dec_op    = (state == ST_DECODE) ? op    : op_q;
   assign dec_funct = (state == ST_DECODE) ? funct : funct_q;

   instr_decode #(
      .OP_W    (OP_W),
      .FUNCT_W (FUNCT_W),
      .ALUOP_W (ALUOP_W)
   ) u_dec (
      .op    (dec_op),
      .funct (dec_funct),
      .cls   (cls),
      .aluop (dec_aluop),
      .legal (legal)
   );

   // next-state and retirement decision
   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         ST_FETCH:  if (mem_ack) state_nxt = ST_DECODE;
         ST_DECODE: state_nxt = legal ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            case (cls)
               CL_R, CL_IMM: state_nxt = ST_WB;
               CL_LW, CL_SW: state_nxt = ST_MEM;
               default: begin
                  state_nxt = ST_FETCH;
                  retire    = 1'b1;
               end
            endcase
         end
         ST_MEM: begin
            if (mem_ack) begin
               if (cls == CL_SW) begin
                  state_nxt = ST_FETCH;
                  retire    = 1'b1;
               end else begin
                  state_nxt = ST_WB;
               end
            end
         end
         ST_WB: begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
         end
         default: state_nxt = ST_TRAP;
      endcase
   end

   // state, run flag, latched IR fields and retired counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_FETCH;
         run     <= 1'b0;
         op_q    <= '0;
         funct_q <= '0;
         retired <= '0;
      end else begin
         run <= 1'b1;
         if (run) begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
               op_q    <= op;
               funct_q <= funct;
            end
            if (retire) retired <= retired + CNT_W'(1);
         end
      end
   end

   // datapath strobes decoded from state and instruction class
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      if_extend  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      aluop      = '0;
      illegal    = 1'b0;
      if (run) begin
         case (state)
            ST_FETCH: begin
               mem_req  = 1'b1;
               ir_write = mem_ack;
               pc_write = mem_ack;
            end
            ST_DECODE: begin
               if (legal && cls == CL_J) begin
                  pc_write = 1'b1;
                  pc_src   = 2'd2;
               end
            end
            ST_EXEC: begin
               case (cls)
                  CL_R: aluop = dec_aluop;
                  CL_IMM, CL_LW, CL_SW: begin
                     alu_src   = 1'b1;
                     if_extend = 1'b1;
                     aluop     = dec_aluop;
                  end
                  CL_BEQ: begin
                     aluop    = dec_aluop;
                     pc_src   = 2'd1;
                     pc_write = alu_zero;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               mem_req = 1'b1;
               mem_we  = (cls == CL_SW);
            end
            ST_WB: begin
               reg_write  = 1'b1;
               reg_dst    = (cls != CL_R);
               mem_to_reg = (cls == CL_LW);
            end
            ST_TRAP: illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model scripts
// the expected output trace cycle by cycle; a negedge process compares.
module tb_multicycle_ctrl;

   localparam int K_R = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

   typedef struct packed {
      logic        mem_req;
      logic        mem_we;
      logic        ir_write;
      logic        pc_write;
      logic [1:0]  pc_src;
      logic        reg_write;
      logic        reg_dst;
      logic        if_extend;
      logic        alu_src;
      logic        mem_to_reg;
      logic [4:0]  aluop;
      logic        illegal;
      logic [31:0] retired;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  op = '0, funct = '0;
   logic        alu_zero = 1'b0, mem_ack = 1'b0;
   logic        mem_req, mem_we, ir_write, pc_write, reg_write, reg_dst;
   logic        if_extend, alu_src, mem_to_reg, illegal;
   logic [1:0]  pc_src;
   logic [4:0]  aluop;
   logic [31:0] retired;

   obs_t        got, want;
   logic        want_vld = 1'b0;
   logic        pin_vld = 1'b0;
   logic [31:0] pin_ret = '0;
   logic [31:0] m_ret = '0;
   logic        ret_pend = 1'b0;
   int          ntot = 0, npass = 0;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .alu_zero(alu_zero),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
      .if_extend(if_extend), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .aluop(aluop), .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   assign got = {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, reg_dst,
                 if_extend, alu_src, mem_to_reg, aluop, illegal, retired};

   // compare DUT against the model away from the active edge
   always @(negedge clk) begin
      if (want_vld) begin
         ntot++;
         if (got === want) npass++;
         else $display("FAIL outputs t=%0t got=%h want=%h", $time, got, want);
      end
      if (pin_vld) begin
         ntot++;
         if (retired === pin_ret) npass++;
         else $display("FAIL retired_pin t=%0t got=%0d want=%0d", $time, retired, pin_ret);
      end
   end

   // ISA table: class and ALU op of an encoding
   function automatic void lookup(input logic [5:0] o, input logic [5:0] f,
                                  output int k, output logic [4:0] a);
      k = K_ILL; a = 5'd0;
      case (o)
         6'h00: begin
            k = K_R;
            case (f)
               6'h20: a = 5'd0;
               6'h21: a = 5'd1;
               6'h23: a = 5'd2;
               6'h24: a = 5'd3;
               6'h25: a = 5'd4;
               6'h2A: a = 5'd5;
               default: k = K_ILL;
            endcase
         end
         6'h02: k = K_J;
         6'h04: begin k = K_BEQ; a = 5'd2; end
         6'h08: begin k = K_IMM; a = 5'd0; end
         6'h09: begin k = K_IMM; a = 5'd1; end
         6'h0C: begin k = K_IMM; a = 5'd3; end
         6'h0D: begin k = K_IMM; a = 5'd4; end
         6'h0F: begin k = K_IMM; a = 5'd6; end
         6'h23: begin k = K_LW;  a = 5'd1; end
         6'h2B: begin k = K_SW;  a = 5'd1; end
         default: k = K_ILL;
      endcase
   endfunction

   // advance one cycle; randomize don't-care inputs, default expectation to idle
   task automatic step();
      @(posedge clk); #1;
      pin_vld = 1'b0;
      if (ret_pend) begin m_ret = m_ret + 32'd1; ret_pend = 1'b0; end
      want = '0;
      want.retired = m_ret;
      mem_ack  = 1'($urandom);
      op       = 6'($urandom);
      funct    = 6'($urandom);
      alu_zero = 1'($urandom);
   endtask

   task automatic idle_pin(input logic [31:0] v);
      step();
      mem_ack = 1'b0; want.mem_req = 1'b1;
      pin_vld = 1'b1; pin_ret = v;
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0; m_ret = '0; ret_pend = 1'b0; want = '0;
      pin_vld = 1'b1; pin_ret = 32'd0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // one instruction: fw/mw are fetch/memory wait cycles, z the ALU zero flag
   task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                            input int fw, input int mw, input logic z);
      int k; logic [4:0] a;
      lookup(iop, ifn, k, a);
      for (int i = 0; i < fw; i++) begin
         step(); mem_ack = 1'b0; want.mem_req = 1'b1;
      end
      step(); mem_ack = 1'b1;
      want.mem_req = 1'b1; want.ir_write = 1'b1; want.pc_write = 1'b1;
      step(); op = iop; funct = ifn;
      if (k == K_J) begin want.pc_write = 1'b1; want.pc_src = 2'd2; end
      if (k == K_ILL) begin
         repeat (12) begin step(); want.illegal = 1'b1; end
         return;
      end
      step();
      case (k)
         K_R: want.aluop = a;
         K_IMM, K_LW, K_SW: begin want.alu_src = 1'b1; want.if_extend = 1'b1; want.aluop = a; end
         K_BEQ: begin
            alu_zero = z; want.aluop = a; want.pc_src = 2'd1; want.pc_write = z;
         end
         default: ;
      endcase
      if (k == K_BEQ || k == K_J) begin ret_pend = 1'b1; return; end
      if (k == K_LW || k == K_SW) begin
         for (int i = 0; i <= mw; i++) begin
            step(); mem_ack = (i == mw);
            want.mem_req = 1'b1; want.mem_we = (k == K_SW);
         end
         if (k == K_SW) begin ret_pend = 1'b1; return; end
      end
      step();
      want.reg_write = 1'b1; want.reg_dst = (k != K_R); want.mem_to_reg = (k == K_LW);
      ret_pend = 1'b1;
   endtask

   logic [5:0] legal_ops [10];
   logic [5:0] r_functs  [6];

   initial begin
      legal_ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
      r_functs  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
      want = '0;
      // reset held: everything idle
      step(); want_vld = 1'b1;
      step();
      step(); rst_n = 1'b1;
      // directed: addu, lw with 2 wait cycles, sw, beq taken/not taken, j
      run_instr(6'h00, 6'h21, 0, 0, 1'b0);
      idle_pin(32'd1);
      run_instr(6'h23, 6'h00, 0, 2, 1'b0);
      idle_pin(32'd2);
      run_instr(6'h2B, 6'h11, 1, 0, 1'b0);
      run_instr(6'h04, 6'h00, 0, 0, 1'b1);
      run_instr(6'h04, 6'h00, 0, 0, 1'b0);
      run_instr(6'h02, 6'h3F, 0, 0, 1'b0);
      idle_pin(32'd6);
      // randomized legal instruction stream
      for (int n = 0; n < 150; n++) begin
         logic [5:0] o, f;
         o = legal_ops[$urandom_range(0, 9)];
         f = (o == 6'h00) ? r_functs[$urandom_range(0, 5)] : 6'($urandom);
         run_instr(o, f, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end
      // reset in the middle of EXEC abandons the instruction
      step(); mem_ack = 1'b1;
      want.mem_req = 1'b1; want.ir_write = 1'b1; want.pc_write = 1'b1;
      step(); op = 6'h00; funct = 6'h20;
      step();
      rst_n = 1'b0; m_ret = '0; ret_pend = 1'b0; want = '0;
      pin_vld = 1'b1; pin_ret = 32'd0;
      step(); rst_n = 1'b1;
      run_instr(6'h09, 6'h00, 0, 0, 1'b0);
      idle_pin(32'd1);
      // illegal opcode, then illegal R-type funct; only reset leaves TRAP
      run_instr(6'h3F, 6'h00, 0, 0, 1'b0);
      do_reset();
      run_instr(6'h0F, 6'h00, 0, 0, 1'b0);
      run_instr(6'h00, 6'h00, 2, 0, 1'b0);
      do_reset();
      run_instr(6'h00, 6'h2A, 0, 0, 1'b0);
      idle_pin(32'd1);
      @(negedge clk); #1;
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
